mc_cfg_loader: RTL and testbench
================================

# mc_cfg_loader

Serial configuration loader that writes the per-macrocell routing select bits consumed by the product-term routing sections, including `pt5_mux` and `pt5_func_mux`. A framed bitstream is accepted under a valid/ready handshake into a shadow register and checked with even parity. Only then is it committed atomically to the live configuration outputs. A bad or aborted frame leaves the live configuration untouched, so the fabric never sees partial routing.

## Interface
Parameters:
- `NUM_MC`, 16: number of macrocells configured.
- `CFG_BITS`, 2: config bits per macrocell. Bit 0 is `pt5_mux`. Bit 1 is `pt5_func_mux`. Bits 2 and up are spare and appear only on `mc_cfg`. `CFG_BITS` must be at least 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cfg_start` input 1: begin a frame. Sampled only in IDLE.
- `cfg_abort` input 1: drop the current frame and return to IDLE. No commit occurs.
- `cfg_bit` input 1: serial data bit.
- `cfg_valid` input 1: `cfg_bit` is valid.
- `cfg_ready` output 1: loader accepts a bit this cycle.
- `busy` output 1: high in every state except IDLE.
- `cfg_done` output 1: one-cycle pulse when a commit occurs.
- `cfg_err` output 1: sticky parity error flag. Cleared by the next accepted `cfg_start`.
- `mc_cfg` output NUM_MC*CFG_BITS: live configuration. Macrocell m owns bits [m*CFG_BITS +: CFG_BITS].
- `pt5_mux` output NUM_MC: bit m = `mc_cfg[m*CFG_BITS]`.
- `pt5_func_mux` output NUM_MC: bit m = `mc_cfg[m*CFG_BITS+1]`.

## Operation
- Frame format: TOTAL = NUM_MC*CFG_BITS data bits, then 1 parity bit.
  - Frame bit k (k < TOTAL) lands at shadow index k, LSB first.
  - The parity bit makes the XOR of all TOTAL+1 bits equal 0 (even parity).
- Counter width: clog2(TOTAL+1). It counts accepted bits 0..TOTAL and does not wrap.
- States:
  - IDLE: `cfg_ready`=0. When `cfg_start`=1: clear the counter, the running parity and `cfg_err`, then go to SHIFT.
  - SHIFT: `cfg_ready`=1. On each handshake (`cfg_valid && cfg_ready`), XOR the bit into running parity. If count < TOTAL, write the bit to shadow[count]. Increment count. The handshake that delivers the parity bit (count == TOTAL) moves to CHECK.
  - CHECK: one cycle, `cfg_ready`=0. If running parity is 0, go to COMMIT. Otherwise set `cfg_err` and go to IDLE.
  - COMMIT: one cycle. Copy the shadow into `mc_cfg`, pulse `cfg_done`, go to IDLE.
- `cfg_abort`:
  - Honoured in SHIFT and CHECK: go to IDLE next cycle, discard the shadow, leave `cfg_err` unchanged.
  - Abort has priority over a same-cycle handshake. The bit is not counted, although `cfg_ready` was high.
  - Ignored in IDLE and COMMIT. Once in COMMIT, the commit always completes.
- `cfg_start` outside IDLE is ignored.
- Shadow contents persist across frames. A new frame fully overwrites them before any commit.
- In SHIFT, cycles with `cfg_valid`=0 are stalls with no state change. Stalls have no limit.

## Timing
- Reset values: state IDLE; `mc_cfg`, `pt5_mux`, `pt5_func_mux`, shadow, counter, parity all 0; `cfg_ready`=0, `busy`=0, `cfg_done`=0, `cfg_err`=0.
  - All-zero config routes every PT5 to its sti5 path.
- Reset asserted mid-frame: immediate return to reset values, including the live config.
- `cfg_start` sampled at edge T: `cfg_ready`=1 from T+1.
- The parity handshake at edge P gives:
  - CHECK during cycle P+1;
  - COMMIT during P+2, with `cfg_done`=1 and `mc_cfg` updated at the P+3 edge;
  - IDLE at P+3.
  - Minimum frame with no stalls: TOTAL+4 cycles from `cfg_start` to the `mc_cfg` update.
- A bad-parity frame sets `cfg_err` at the P+2 edge and is back in IDLE at P+2.
- All outputs are registered. `cfg_ready` and `busy` decode directly from the state register. No combinational path from inputs to outputs.
- The earliest next `cfg_start` is the cycle after `cfg_done`.

## Test plan
All scenarios use `NUM_MC`=4, `CFG_BITS`=2 (TOTAL=8).

- Reset: hold `rst_n`=0, then release. All outputs are 0, `cfg_ready`=0, and a `cfg_bit` toggling with `cfg_valid`=1 has no effect.
- Good frame: data bits k0..k7 = 1,0,0,1,1,1,0,0, parity 0, no stalls.
  - `mc_cfg`=8'h39, `pt5_mux`=4'b0101, `pt5_func_mux`=4'b0110.
  - `cfg_done` pulses exactly 12 cycles after `cfg_start`.
- Bad parity: after the good frame, send data 8'hFF with parity 1.
  - `cfg_err`=1, no `cfg_done`, `mc_cfg` stays 8'h39.
  - The next `cfg_start` clears `cfg_err`.
- Stalls: good frame with `cfg_valid` low on random cycles (up to 5 in a row). Same result as the good-frame scenario; the counter never advances on a stall.
- Abort: assert `cfg_abort` together with the 5th handshake.
  - IDLE next cycle, `mc_cfg` unchanged.
  - A following full frame of 8'hA6 plus correct parity commits 8'hA6, showing the aborted bit was not counted.
- Async reset mid-frame: drop `rst_n` between edges during bit 3. Outputs clear immediately without waiting for a clock edge, and `busy`=0.

Source files
------------

// File: rtl/mc_cfg_loader.sv
// -----------------------------------------------------------------------------
// mc_cfg_loader
//
// Serial configuration loader for the per-macrocell PT5 routing selects.
// A framed bitstream (NUM_MC*CFG_BITS data bits, LSB first, then one even
// parity bit) is shifted into a shadow register under a valid/ready
// handshake. The shadow is copied to the live configuration in a single
// cycle only after the parity checks out. Bad or aborted frames never touch
// the live configuration, so the routing fabric never sees a partial update.
//
// Parameters:
//   NUM_MC        number of macrocells configured
//   CFG_BITS      config bits per macrocell (>= 2); bit 0 = pt5_mux,
//                 bit 1 = pt5_func_mux, higher bits are spare (mc_cfg only)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   cfg_start     begin a frame (sampled only in IDLE)
//   cfg_abort     drop the current frame (SHIFT/CHECK only), no commit
//   cfg_bit       serial data bit
//   cfg_valid     cfg_bit is valid
//   cfg_ready     loader accepts a bit this cycle (SHIFT state)
//   busy          high in every state except IDLE
//   cfg_done      one-cycle pulse when the live configuration is updated
//   cfg_err       sticky parity error, cleared by the next accepted cfg_start
//   mc_cfg        live configuration, macrocell m at [m*CFG_BITS +: CFG_BITS]
//   pt5_mux       bit m = mc_cfg[m*CFG_BITS]
//   pt5_func_mux  bit m = mc_cfg[m*CFG_BITS+1]
// -----------------------------------------------------------------------------
module mc_cfg_loader #(
   parameter int NUM_MC   = 16,
   parameter int CFG_BITS = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_start,
   input  logic                       cfg_abort,
   input  logic                       cfg_bit,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   output logic                       busy,
   output logic                       cfg_done,
   output logic                       cfg_err,
   output logic [NUM_MC*CFG_BITS-1:0] mc_cfg,
   output logic [NUM_MC-1:0]          pt5_mux,
   output logic [NUM_MC-1:0]          pt5_func_mux
);

   localparam int TOTAL = NUM_MC * CFG_BITS;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_CHECK  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   state_t               state_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 par_r;
   logic [TOTAL-1:0]     shadow_r;
   logic [TOTAL-1:0]     mc_cfg_r;
   logic                 done_r;
   logic                 err_r;

   // Running even-parity accumulator step.
   function automatic logic parity_step(input logic acc, input logic din);
      return acc ^ din;
   endfunction

   // Loader FSM: frame capture, parity check, atomic commit and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         par_r    <= 1'b0;
         shadow_r <= {TOTAL{1'b0}};
         mc_cfg_r <= {TOTAL{1'b0}};
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cfg_start) begin
                  cnt_r   <= {CNT_W{1'b0}};
                  par_r   <= 1'b0;
                  err_r   <= 1'b0;
                  state_r <= ST_SHIFT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               // Abort wins over a same-cycle handshake: that bit is dropped.
               if (cfg_abort) begin
                  state_r <= ST_IDLE;
               end else if (cfg_valid) begin
                  par_r <= parity_step(par_r, cfg_bit);
                  if (cnt_r < CNT_W'(TOTAL)) begin
                     shadow_r[cnt_r[IDX_W-1:0]] <= cfg_bit;
                     cnt_r                      <= cnt_r + CNT_W'(1);
                  end else begin
                     // Parity bit: counter holds at TOTAL rather than wrapping.
                     state_r <= ST_CHECK;
                  end
               end else begin
                  state_r <= ST_SHIFT;
               end
            end
            ST_CHECK: begin
               if (cfg_abort) begin
                  state_r <= ST_IDLE;
               end else if (par_r == 1'b0) begin
                  state_r <= ST_COMMIT;
               end else begin
                  err_r   <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            ST_COMMIT: begin
               // Commit is not abortable once entered.
               mc_cfg_r <= shadow_r;
               done_r   <= 1'b1;
               state_r  <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign cfg_ready = (state_r == ST_SHIFT);
   assign busy      = (state_r != ST_IDLE);
   assign cfg_done  = done_r;
   assign cfg_err   = err_r;
   assign mc_cfg    = mc_cfg_r;

   // Fan the two routing selects of each macrocell out to their own buses.
   for (genvar m = 0; m < NUM_MC; m++) begin : g_route
      assign pt5_mux[m]      = mc_cfg_r[m*CFG_BITS];
      assign pt5_func_mux[m] = mc_cfg_r[m*CFG_BITS+1];
   end

endmodule

// File: tb/tb_mc_cfg_loader.sv
module tb_mc_cfg_loader;

   localparam int NUM_MC   = 4;
   localparam int CFG_BITS = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_start;
   logic       cfg_abort;
   logic       cfg_bit;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       busy;
   logic       cfg_done;
   logic       cfg_err;
   logic [7:0] mc_cfg;
   logic [3:0] pt5_mux;
   logic [3:0] pt5_func_mux;

   int n_tests   = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int done_seen = 0;
   int at        = 0;

   int stall_tbl [9] = '{0, 2, 5, 1, 3, 0, 4, 5, 2};

   always #5 clk = ~clk;

   mc_cfg_loader #(
      .NUM_MC   (NUM_MC),
      .CFG_BITS (CFG_BITS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_start    (cfg_start),
      .cfg_abort    (cfg_abort),
      .cfg_bit      (cfg_bit),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .busy         (busy),
      .cfg_done     (cfg_done),
      .cfg_err      (cfg_err),
      .mc_cfg       (mc_cfg),
      .pt5_mux      (pt5_mux),
      .pt5_func_mux (pt5_func_mux)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: through the rising edge, sample on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cfg_done === 1'b1) done_seen++;
   endtask

   task automatic start_frame();
      cyc       = 0;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int stall);
      for (int s = 0; s < stall; s++) begin
         cfg_valid = 1'b0;
         cfg_bit   = ~b;
         tick();
      end
      cfg_valid = 1'b1;
      cfg_bit   = b;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p);
      for (int i = 0; i < 8; i++) send_bit(d[i], 0);
      send_bit(p, 0);
   endtask

   // Bounded wait for cfg_done; returns cycles since cfg_start, or -1.
   task automatic wait_done(output int when);
      when = -1;
      for (int i = 0; i < 40; i++) begin
         if (cfg_done === 1'b1) begin
            when = cyc;
            break;
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      cfg_bit   = 1'b0;
      cfg_valid = 1'b1;

      // Reset: bits toggling with valid high must have no effect.
      for (int i = 0; i < 3; i++) begin
         cfg_bit = ~cfg_bit;
         tick();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cfg_bit = ~cfg_bit;
         tick();
         chk("rst_ready", 32'(cfg_ready), 32'd0);
      end
      cfg_valid = 1'b0;
      chk("rst_mc_cfg", 32'(mc_cfg), 32'h00);
      chk("rst_pt5", 32'(pt5_mux), 32'h0);
      chk("rst_func", 32'(pt5_func_mux), 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(cfg_done), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);

      // Good frame: 1,0,0,1,1,1,0,0 -> 8'h39, parity 0.
      done_seen = 0;
      start_frame();
      chk("good_ready", 32'(cfg_ready), 32'd1);
      chk("good_busy", 32'(busy), 32'd1);
      send_frame(8'h39, 1'b0);
      chk("check_ready", 32'(cfg_ready), 32'd0);
      chk("check_busy", 32'(busy), 32'd1);
      chk("check_mc_cfg", 32'(mc_cfg), 32'h00);
      wait_done(at);
      chk("good_latency", 32'(at), 32'd12);
      chk("good_mc_cfg", 32'(mc_cfg), 32'h39);
      chk("good_pt5", 32'(pt5_mux), 32'b0101);
      chk("good_func", 32'(pt5_func_mux), 32'b0110);
      tick();
      chk("done_pulse", 32'(cfg_done), 32'd0);
      chk("good_idle", 32'(busy), 32'd0);
      chk("good_done_cnt", 32'(done_seen), 32'd1);

      // Bad parity: 8'hFF with parity 1.
      done_seen = 0;
      start_frame();
      send_frame(8'hFF, 1'b1);
      tick();
      chk("bad_err", 32'(cfg_err), 32'd1);
      chk("bad_idle", 32'(busy), 32'd0);
      tick();
      tick();
      chk("bad_no_done", 32'(done_seen), 32'd0);
      chk("bad_mc_cfg", 32'(mc_cfg), 32'h39);
      chk("bad_err_sticky", 32'(cfg_err), 32'd1);

      // Stalled good frame; next start clears the error.
      start_frame();
      chk("start_clr_err", 32'(cfg_err), 32'd0);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] d;
         d = 8'h39;
         send_bit(d[i], stall_tbl[i]);
      end
      send_bit(1'b0, stall_tbl[8]);
      wait_done(at);
      chk("stall_latency", 32'(at), 32'd34);
      chk("stall_mc_cfg", 32'(mc_cfg), 32'h39);
      tick();

      // Abort together with the 5th handshake.
      start_frame();
      for (int i = 0; i < 4; i++) begin
         logic [7:0] d;
         d = 8'hA6;
         send_bit(d[i], 0);
      end
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      cfg_valid = 1'b0;
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_ready", 32'(cfg_ready), 32'd0);
      chk("abort_mc_cfg", 32'(mc_cfg), 32'h39);
      chk("abort_err", 32'(cfg_err), 32'd0);

      // Full A6 frame; a stray cfg_start mid-frame must be ignored.
      start_frame();
      for (int i = 0; i < 8; i++) begin
         logic [7:0] d;
         d = 8'hA6;
         if (i == 3) cfg_start = 1'b1;
         send_bit(d[i], 0);
         cfg_start = 1'b0;
      end
      send_bit(1'b0, 0);
      wait_done(at);
      chk("a6_latency", 32'(at), 32'd12);
      chk("a6_mc_cfg", 32'(mc_cfg), 32'hA6);
      chk("a6_pt5", 32'(pt5_mux), 32'b0010);
      chk("a6_func", 32'(pt5_func_mux), 32'b1101);
      tick();

      // Abort during CHECK: no commit, no error.
      done_seen = 0;
      start_frame();
      send_frame(8'h5A, 1'b0);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      chk("chk_abort_idle", 32'(busy), 32'd0);
      tick();
      tick();
      chk("chk_abort_done", 32'(done_seen), 32'd0);
      chk("chk_abort_err", 32'(cfg_err), 32'd0);
      chk("chk_abort_mc_cfg", 32'(mc_cfg), 32'hA6);

      // Asynchronous reset between edges during bit 3.
      start_frame();
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_mc_cfg", 32'(mc_cfg), 32'h00);
      chk("arst_pt5", 32'(pt5_mux), 32'h0);
      chk("arst_func", 32'(pt5_func_mux), 32'h0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      cfg_valid = 1'b0;
      rst_n     = 1'b1;
      tick();
      chk("arst_after_busy", 32'(busy), 32'd0);
      chk("arst_after_mc_cfg", 32'(mc_cfg), 32'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
